// File: rtl/dcache_store_buffer_if.sv
// Bus bundle between the store buffer, the writeback/memory stages and the dcache write port.
// The slave modport is the buffer's view; master is the surrounding pipeline/dcache view.
interface dcache_store_buffer_if;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [63:0] st_data;
   logic        st_size;
   logic        wr_req_valid;
   logic        wr_req_ready;
   logic [31:0] wr_req_address;
   logic [63:0] wr_req_data;
   logic        wr_size_out;
   logic        rd_chk_valid;
   logic [31:0] rd_chk_addr;
   logic        rd_conflict;
   logic        sb_empty;

   modport slave (
      input  st_valid, st_addr, st_data, st_size,
      input  wr_req_ready,
      input  rd_chk_valid, rd_chk_addr,
      output st_ready,
      output wr_req_valid, wr_req_address, wr_req_data, wr_size_out,
      output rd_conflict, sb_empty
   );

   modport master (
      output st_valid, st_addr, st_data, st_size,
      output wr_req_ready,
      output rd_chk_valid, rd_chk_addr,
      input  st_ready,
      input  wr_req_valid, wr_req_address, wr_req_data, wr_size_out,
      input  rd_conflict, sb_empty
   );
endinterface

// File: rtl/dcache_store_buffer.sv
// FIFO of retired stores draining into the dcache write port, with a conservative
// load-overlap check so the memory stage can stall loads that hit a buffered store.
module dcache_store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input logic                  clk,
   input logic                  reset,
   dcache_store_buffer_if.slave bus
);

   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] data;
      logic        size;
   } entry_t;

   entry_t            entries [DEPTH];
   logic [DEPTH-1:0]  entry_valid;
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [PTR_W:0]    count;
   logic              enq;
   logic              deq;
   logic [28:0]       load_block;
   logic [DEPTH-1:0]  hit;
   logic              unused_rd_offset;

   // Ready/valid come from registered count only, so a full buffer never reuses a slot same-cycle
   assign bus.st_ready       = (count != (PTR_W+1)'(DEPTH));
   assign bus.wr_req_valid   = (count != '0);
   assign bus.sb_empty       = (count == '0);
   assign enq                = bus.st_valid & bus.st_ready;
   assign deq                = bus.wr_req_valid & bus.wr_req_ready;

   assign bus.wr_req_address = entries[head].addr;
   assign bus.wr_req_data    = entries[head].data;
   assign bus.wr_size_out    = entries[head].size;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         entry_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         if (enq) begin
            entries[tail]     <= '{addr: bus.st_addr, data: bus.st_data, size: bus.st_size};
            entry_valid[tail] <= 1'b1;
            tail              <= tail + 1'b1;
         end
         if (deq) begin
            entry_valid[head] <= 1'b0;
            head              <= head + 1'b1;
         end
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Stores and loads each span their 8-byte block plus the next one; block arithmetic wraps at 29 bits
   assign load_block       = bus.rd_chk_addr[31:3];
   assign unused_rd_offset = ^bus.rd_chk_addr[2:0];

   for (genvar g = 0; g < DEPTH; g++) begin : g_hit
      logic [28:0] blk;
      assign blk    = entries[g].addr[31:3];
      assign hit[g] = entry_valid[g] &
                      ((blk == load_block) |
                       (blk == load_block + 29'd1) |
                       (blk + 29'd1 == load_block));
   end

   assign bus.rd_conflict = bus.rd_chk_valid & (|hit);

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Scoreboard bench for dcache_store_buffer: directed scenarios plus randomized traffic,
// with a queue-based reference model checked by an independent negedge monitor.
module tb_dcache_store_buffer;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      logic [63:0] data;
      logic        size;
   } store_t;

   logic   clk   = 1'b0;
   logic   reset = 1'b0;
   store_t exp_q[$];
   bit     pend_enq;
   int     checks;
   int     fails;

   always #5 clk = ~clk;

   dcache_store_buffer_if bus ();

   dcache_store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic void check_output(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Overlap of the two-block windows {E,E+1} and {L,L+1}, with 29-bit wrap
   function automatic bit model_conflict(int held, logic rv, logic [31:0] ra);
      logic [28:0] e;
      logic [28:0] l;
      logic [28:0] ea;
      logic [28:0] lb;
      if (!rv) return 1'b0;
      l = ra[31:3];
      for (int i = 0; i < held; i++) begin
         e = exp_q[i].addr[31:3];
         for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
               ea = e + 29'(a);
               lb = l + 29'(b);
               if (ea == lb) return 1'b1;
            end
         end
      end
      return 1'b0;
   endfunction

   // One cycle of stimulus, applied just after the rising edge; model accepts while not full
   task automatic apply_stimulus(input logic stv, input logic [31:0] sa, input logic [63:0] sd,
                                 input logic ss, input logic wrdy, input logic rv,
                                 input logic [31:0] ra);
      store_t s;
      @(posedge clk);
      #1;
      bus.st_valid     = stv;
      bus.st_addr      = sa;
      bus.st_data      = sd;
      bus.st_size      = ss;
      bus.wr_req_ready = wrdy;
      bus.rd_chk_valid = rv;
      bus.rd_chk_addr  = ra;
      pend_enq = stv && (exp_q.size() < DEPTH);
      if (pend_enq) begin
         s.addr = sa;
         s.data = sd;
         s.size = ss;
         exp_q.push_back(s);
      end
   endtask

   task automatic idle(input logic wrdy);
      apply_stimulus(1'b0, 32'h0, 64'h0, 1'b0, wrdy, 1'b0, 32'h0);
   endtask

   task automatic load_check(input logic rv, input logic [31:0] ra, input logic exp, input string name);
      apply_stimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, rv, ra);
      #1;
      check_output(name, bus.rd_conflict, exp);
   endtask

   // Monitor: the entries actually held exclude a store that will only land at the next edge
   always @(negedge clk) begin
      int held;
      if (reset) begin
         held = exp_q.size() - (pend_enq ? 1 : 0);
         check_output("st_ready", bus.st_ready, held != DEPTH);
         check_output("wr_req_valid", bus.wr_req_valid, held != 0);
         check_output("sb_empty", bus.sb_empty, held == 0);
         check_output("rd_conflict", bus.rd_conflict,
                      model_conflict(held, bus.rd_chk_valid, bus.rd_chk_addr));
         if (held > 0) begin
            check_output("wr_req_address", bus.wr_req_address, exp_q[0].addr);
            check_output("wr_req_data", bus.wr_req_data, exp_q[0].data);
            check_output("wr_size_out", bus.wr_size_out, exp_q[0].size);
            if (bus.wr_req_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] sa;
      logic        ss;
      logic [63:0] sd;
      checks   = 0;
      fails    = 0;
      pend_enq = 1'b0;
      bus.st_valid     = 1'b0;
      bus.st_addr      = '0;
      bus.st_data      = '0;
      bus.st_size      = 1'b0;
      bus.wr_req_ready = 1'b0;
      bus.rd_chk_valid = 1'b0;
      bus.rd_chk_addr  = '0;

      #1;
      check_output("reset_st_ready", bus.st_ready, 1'b1);
      check_output("reset_wr_req_valid", bus.wr_req_valid, 1'b0);
      check_output("reset_sb_empty", bus.sb_empty, 1'b1);
      check_output("reset_address", bus.wr_req_address, 32'h0);
      check_output("reset_data", bus.wr_req_data, 64'h0);
      check_output("reset_size", bus.wr_size_out, 1'b0);
      check_output("reset_conflict", bus.rd_conflict, 1'b0);
      #20;
      @(negedge clk);
      #2 reset = 1'b1;

      $display("[TB] single store passes straight through");
      apply_stimulus(1'b1, 32'h1000, 64'h11223344, 1'b0, 1'b0, 1'b0, 32'h0);
      idle(1'b1);
      #1;
      check_output("t1_valid", bus.wr_req_valid, 1'b1);
      check_output("t1_addr", bus.wr_req_address, 32'h1000);
      check_output("t1_data", bus.wr_req_data, 64'h11223344);
      check_output("t1_size", bus.wr_size_out, 1'b0);
      idle(1'b0);
      #1;
      check_output("t1_empty", bus.sb_empty, 1'b1);

      $display("[TB] fill to full, then drain in order");
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b1, 32'h100 + 32'(i * 8), 64'hA0 + 64'(i), 1'b1, 1'b0, 1'b0, 32'h0);
      end
      apply_stimulus(1'b1, 32'h200, 64'hA4, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      check_output("t2_full", bus.st_ready, 1'b0);
      apply_stimulus(1'b1, 32'h200, 64'hA4, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      check_output("t2_full_hold", bus.st_ready, 1'b0);
      apply_stimulus(1'b1, 32'h200, 64'hA4, 1'b0, 1'b1, 1'b0, 32'h0);
      #1;
      check_output("t2_full_during_deq", bus.st_ready, 1'b0);
      apply_stimulus(1'b1, 32'h200, 64'hA4, 1'b0, 1'b1, 1'b0, 32'h0);
      #1;
      check_output("t2_ready_after_deq", bus.st_ready, 1'b1);
      for (int i = 0; i < 6; i++) idle(1'b1);
      #1;
      check_output("t2_drained", bus.sb_empty, 1'b1);

      $display("[TB] steady enqueue+dequeue at count 2 with pointer wrap");
      apply_stimulus(1'b1, 32'h300, 64'hB0, 1'b0, 1'b0, 1'b0, 32'h0);
      apply_stimulus(1'b1, 32'h308, 64'hB1, 1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 2; i < 12; i++) begin
         apply_stimulus(1'b1, 32'h300 + 32'(i * 8), 64'hB0 + 64'(i), i[0], 1'b1, 1'b0, 32'h0);
      end
      for (int i = 0; i < 6; i++) idle(1'b1);

      $display("[TB] load conflict windows");
      apply_stimulus(1'b1, 32'h2004, 64'hC0FFEE, 1'b1, 1'b0, 1'b0, 32'h0);
      load_check(1'b1, 32'h2008, 1'b1, "t4_next_block");
      load_check(1'b1, 32'h2010, 1'b0, "t4_two_blocks_up");
      load_check(1'b1, 32'h3000, 1'b0, "t4_far");
      load_check(1'b0, 32'h2008, 1'b0, "t4_no_valid");
      for (int i = 0; i < 3; i++) idle(1'b1);
      apply_stimulus(1'b1, 32'hFFFF_FFF8, 64'h5A5A, 1'b1, 1'b0, 1'b0, 32'h0);
      load_check(1'b1, 32'h0000_0000, 1'b1, "t5_wrap");

      $display("[TB] asynchronous reset with entries held");
      apply_stimulus(1'b1, 32'h4000, 64'hD0, 1'b0, 1'b0, 1'b0, 32'h0);
      apply_stimulus(1'b1, 32'h4008, 64'hD1, 1'b0, 1'b0, 1'b0, 32'h0);
      idle(1'b0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      bus.st_valid     = 1'b0;
      bus.wr_req_ready = 1'b0;
      pend_enq         = 1'b0;
      exp_q.delete();
      #1;
      check_output("t6_valid", bus.wr_req_valid, 1'b0);
      check_output("t6_empty", bus.sb_empty, 1'b1);
      check_output("t6_ready", bus.st_ready, 1'b1);
      @(negedge clk);
      #2 reset = 1'b1;
      apply_stimulus(1'b1, 32'h5000, 64'hE0, 1'b1, 1'b0, 1'b0, 32'h0);
      idle(1'b1);
      #1;
      check_output("t6_new_addr", bus.wr_req_address, 32'h5000);
      idle(1'b0);
      #1;
      check_output("t6_alone", bus.sb_empty, 1'b1);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         sa = 32'h4000 + (32'($urandom_range(0, 31)) << 3) + (32'($urandom_range(0, 1)) << 2);
         ss = 1'($urandom_range(0, 1));
         sd = ss ? {$urandom, $urandom} : {32'h0, $urandom};
         ra = 32'h4000 + (32'($urandom_range(0, 511)) << 2);
         apply_stimulus(1'($urandom_range(0, 1)), sa, sd, ss,
                        ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), ra);
      end
      for (int i = 0; i < 8; i++) idle(1'b1);
      #1;
      check_output("final_empty", bus.sb_empty, 1'b1);
      check_output("final_model_empty", 64'(exp_q.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
